bus_line_requester: RTL and testbench

Requester-side agent for the shared line memory bus: accepts one line read or write command from the cache, raises a request toward the bus arbiter, waits for the grant, performs the 66-bit line transfer ({MESI[1:0], data[63:0]}), returns the result, and releases the bus. One instance sits in front of each requester (CPU cache, external agent); together they form the other end of the arbiter's req/gnt handshake.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_req_timer.sv | 35 +++
 rtl/bus_line_requester.sv | 170 +++++++++++++++++
 tb/tb_bus_line_requester.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types for the line memory bus requester.
// Line format, MESI encoding and requester FSM states.
package bus_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } Tmesi_state;

    typedef struct packed {
        Tmesi_state  mesi;
        logic [63:0] data;
    } Tline;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } Treq_state;

endpackage

// File: rtl/bus_req_timer.sv
// Loadable 8-bit down-counter shared by grant timeout and read latency.
// expired marks the last counted cycle (count == 1).
module bus_req_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Load wins; otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 8'd1);

endmodule

// File: rtl/bus_line_requester.sv
// Requester-side agent: one cache line command per bus tenure.
// Handles grant timeout, preemption retry and stale-grant release.
module bus_line_requester #(
    parameter int ADDR_W  = 32,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [63:0]       cmd_wdata,
    input  logic [1:0]        cmd_mesi,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [63:0]       rsp_data,
    output logic [1:0]        rsp_mesi,
    output logic              req,
    input  logic              gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [65:0]       write_line,
    input  logic [65:0]       read_line
);

    import bus_pkg::*;

    localparam logic [7:0] TO_LD  = 8'(TIMEOUT);
    localparam logic [7:0] LAT_LD = 8'(RD_LAT);

    Treq_state         state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    Tmesi_state        mesi_q, mesi_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [63:0]       rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_mesi_q, rsp_mesi_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_we_q, bus_we_d;
    logic [65:0]       wline_q, wline_d;
    logic              tmr_load;
    logic [7:0]        tmr_val;
    logic              tmr_exp;
    Tline              rline;
    Tline              wline;

    assign cmd_ready = reset && (state_q == ST_IDLE);
    assign rline     = Tline'(read_line);

    bus_req_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    // Next-state, command capture and registered output values.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mesi_d      = mesi_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_mesi_d  = rsp_mesi_q;
        bus_we_d    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = TO_LD;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    we_d     = cmd_we;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    mesi_d   = Tmesi_state'(cmd_mesi);
                    tmr_load = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (gnt) begin
                    bus_we_d = we_q;
                    tmr_load = 1'b1;
                    tmr_val  = LAT_LD;
                    state_d  = ST_XFER;
                end else if (tmr_exp) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RELEASE;
                end
            end
            ST_XFER: begin
                if (!gnt) begin
                    tmr_load = 1'b1;
                    state_d  = ST_REQ;
                end else if (we_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RELEASE;
                end else if (tmr_exp) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rline.data;
                    rsp_mesi_d  = rline.mesi;
                    state_d     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!gnt) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wline.mesi = mesi_q;
        wline.data = wdata_q;
        req_d      = (state_d == ST_REQ) || (state_d == ST_XFER);
        bus_addr_d = req_d ? addr_d : '0;
        wline_d    = bus_we_d ? wline : '0;
    end

    // State, captured command and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mesi_q      <= MESI_I;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_mesi_q  <= '0;
            req_q       <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            wline_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mesi_q      <= mesi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_mesi_q  <= rsp_mesi_d;
            req_q       <= req_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            wline_q     <= wline_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_mesi   = rsp_mesi_q;
    assign req        = req_q;
    assign bus_addr   = bus_addr_q;
    assign bus_we     = bus_we_q;
    assign write_line = wline_q;

endmodule

// File: tb/tb_bus_line_requester.sv
// Directed bench for bus_line_requester (RD_LAT=2, TIMEOUT=8).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bus_line_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [1:0]  cmd_mesi;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_mesi;
    logic        req;
    logic        gnt;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [65:0] write_line;
    logic [65:0] read_line;

    int n_chk  = 0;
    int n_pass = 0;
    int we_cnt = 0;
    int we_base;

    localparam logic [63:0] WD1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] RD1 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] RD2 = 64'hCAFE_F00D_0BAD_1DEA;
    localparam logic [63:0] WDA = 64'hAAAA_0000_1111_2222;
    localparam logic [63:0] WDB = 64'hBBBB_3333_4444_5555;

    bus_line_requester #(
        .ADDR_W  (32),
        .RD_LAT  (2),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_mesi   (cmd_mesi),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .rsp_mesi   (rsp_mesi),
        .req        (req),
        .gnt        (gnt),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .write_line (write_line),
        .read_line  (read_line)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [63:0] d, input logic [1:0] m);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_mesi  = m;
    endtask

    task automatic scramble();
        cmd_valid = 1'b0;
        cmd_we    = ~cmd_we;
        cmd_addr  = 32'hFFFF_FFF0;
        cmd_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
        cmd_mesi  = 2'b10;
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_mesi  = '0;
        gnt       = 1'b0;
        read_line = '0;
        #1;
        tick();
        tick();
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_outs",
            {req, bus_we, rsp_valid, rsp_err}, 4'b0);
        chk("rst_vals",
            {write_line, bus_addr, rsp_data, rsp_mesi}, '0);
        reset = 1'b1;
        tick();
        chk("rst_ready_after", cmd_ready, 1'b1);

        // Write line, grant two cycles after req rises.
        we_base = we_cnt;
        issue(1'b1, 32'h40, WD1, 2'b11);
        tick();
        scramble();
        chk("wr_req", {req, cmd_ready, bus_we}, 3'b100);
        chk("wr_addr", bus_addr, 32'h40);
        tick();
        chk("wr_wait", {req, bus_we}, 2'b10);
        tick();
        gnt = 1'b1;
        chk("wr_nowe_yet", bus_we, 1'b0);
        tick();
        chk("wr_we", {bus_we, rsp_valid}, 2'b10);
        chk("wr_line", write_line, {2'b11, WD1});
        chk("wr_bus_addr", bus_addr, 32'h40);
        tick();
        chk("wr_rsp", {rsp_valid, rsp_err, bus_we, req}, 4'b1000);
        chk("wr_line_clr", {write_line, bus_addr}, '0);
        tick();
        gnt = 1'b0;
        chk("wr_pulse", {rsp_valid, cmd_ready}, 2'b00);
        tick();
        chk("wr_idle", cmd_ready, 1'b1);
        chk("wr_we_count", we_cnt - we_base, 1);

        // Read line, RD_LAT=2.
        issue(1'b0, 32'h80, 64'h0, 2'b00);
        read_line = {2'b11, 64'hFFFF_FFFF_FFFF_FFFF};
        tick();
        scramble();
        gnt = 1'b1;
        tick();
        chk("rd_x1", {req, bus_we, rsp_valid}, 3'b100);
        tick();
        read_line = {2'b01, RD1};
        chk("rd_x2", rsp_valid, 1'b0);
        tick();
        read_line = '0;
        chk("rd_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("rd_data", {rsp_mesi, rsp_data}, {2'b01, RD1});
        chk("rd_req_low", req, 1'b0);
        tick();
        gnt = 1'b0;
        chk("rd_hold", {rsp_valid, rsp_mesi, rsp_data}, {1'b0, 2'b01, RD1});
        tick();
        chk("rd_idle", cmd_ready, 1'b1);

        // Grant timeout, TIMEOUT=8.
        issue(1'b0, 32'h100, 64'h0, 2'b00);
        tick();
        scramble();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("to_wait%0d", k), {req, rsp_valid}, 2'b10);
            tick();
        end
        chk("to_rsp", {rsp_valid, rsp_err, req}, 3'b110);
        chk("to_data_held", rsp_data, RD1);
        tick();
        chk("to_idle", {cmd_ready, rsp_valid, rsp_err}, 3'b100);

        // Back-to-back writes, grant drops one cycle late.
        we_base = we_cnt;
        issue(1'b1, 32'h200, WDA, 2'b10);
        tick();
        issue(1'b1, 32'h300, WDB, 2'b01);
        gnt = 1'b1;
        tick();
        chk("bb_a_we", {bus_we, write_line}, {1'b1, 2'b10, WDA});
        tick();
        chk("bb_a_rsp", {rsp_valid, req}, 2'b10);
        tick();
        chk("bb_late_gnt", {req, cmd_ready}, 2'b00);
        tick();
        gnt = 1'b0;
        chk("bb_still_rel", {req, cmd_ready}, 2'b00);
        tick();
        chk("bb_idle", {req, cmd_ready}, 2'b01);
        tick();
        scramble();
        gnt = 1'b1;
        chk("bb_b_req", {req, bus_addr}, {1'b1, 32'h300});
        tick();
        chk("bb_b_we", {bus_we, write_line}, {1'b1, 2'b01, WDB});
        tick();
        gnt = 1'b0;
        chk("bb_b_rsp", {rsp_valid, rsp_err}, 2'b10);
        tick();
        chk("bb_done", cmd_ready, 1'b1);
        chk("bb_we_count", we_cnt - we_base, 2);

        // Grant drops mid-read, then re-grant.
        issue(1'b0, 32'h500, 64'h0, 2'b00);
        tick();
        scramble();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        read_line = {2'b11, 64'h0};
        tick();
        chk("pre_abort", {req, rsp_valid, bus_addr}, {2'b10, 32'h500});
        tick();
        gnt = 1'b1;
        chk("pre_req_held", {req, rsp_valid}, 2'b10);
        tick();
        tick();
        read_line = {2'b10, RD2};
        chk("pre_no_rsp", rsp_valid, 1'b0);
        tick();
        gnt = 1'b0;
        read_line = '0;
        chk("pre_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("pre_data", {rsp_mesi, rsp_data}, {2'b10, RD2});
        tick();
        chk("pre_idle", cmd_ready, 1'b1);

        // Reset during a write transfer.
        issue(1'b1, 32'h600, WDA, 2'b11);
        tick();
        scramble();
        gnt = 1'b1;
        tick();
        chk("rx_we", bus_we, 1'b1);
        reset = 1'b0;
        tick();
        chk("rx_outs", {req, bus_we, rsp_valid, rsp_err, cmd_ready}, 5'b0);
        chk("rx_vals", {write_line, bus_addr, rsp_data}, '0);
        reset = 1'b1;
        gnt = 1'b0;
        tick();
        chk("rx_ready", {cmd_ready, rsp_valid, req}, 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
